// File: rtl/mem_test_pkg.sv
// Shared types and helpers for the memTest data-bus walker.
package mem_test_pkg;

  // Controller states of the data-bus walker.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WRITE     = 4'd1,
    S_READ_REQ  = 4'd2,
    S_READ_WAIT = 4'd3,
    S_NEXT      = 4'd4,
    S_FAIL      = 4'd5,
    S_DONE      = 4'd6
  } state_t;

  // Pattern polarity: a single 1 in zeros, or a single 0 in ones.
  typedef enum logic {
    WALK_ONES  = 1'b0,
    WALK_ZEROS = 1'b1
  } mode_t;

  // Width of a counter that must hold 0..timeout_cycles; never narrower than 1.
  function automatic int tmo_cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_test_pattern_walker.sv
// Pattern register for the data-bus walker: loads the first pattern,
// rotates it left one bit per shift and tracks which bit is under test.
module mem_test_pattern_walker
  import mem_test_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n_async,
  input  logic                  load,
  input  mode_t                 mode,
  input  logic                  shift,
  output logic [DATA_WIDTH-1:0] pattern,
  output logic [IDX_WIDTH-1:0]  index,
  output logic                  last
);

  localparam logic [DATA_WIDTH-1:0] FIRST_ONE = DATA_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(DATA_WIDTH - 1);

  // Load seeds bit 0; shift rotates so the odd bit (1 or 0) walks upward.
  always_ff @(posedge i_clk or negedge i_rst_n_async) begin
    if (!i_rst_n_async) begin
      pattern <= '0;
      index   <= '0;
    end else if (load) begin
      pattern <= (mode == WALK_ZEROS) ? ~FIRST_ONE : FIRST_ONE;
      index   <= '0;
    end else if (shift) begin
      pattern <= {pattern[DATA_WIDTH-2:0], pattern[DATA_WIDTH-1]};
      index   <= index + IDX_WIDTH'(1);
    end
  end

  assign last = (index == LAST_IDX);

endmodule

// File: rtl/mem_test_data_bus_walker.sv
// Data-bus test engine: walks a ones/zeros pattern across every data bit
// at one address, writing then reading back each pattern, and reports
// pass, miscompare or read-response timeout.
//
// Request handshake: o_mem_req_valid is raised with address, write data and
// we already stable, and all of them are held unchanged until the cycle in
// which i_mem_req_ready is also high; that cycle is the transfer. Read data
// is only taken while waiting for it (READ_WAIT) on i_mem_rsp_valid; there
// is no backpressure on responses.
module mem_test_data_bus_walker
  import mem_test_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int IDX_WIDTH      = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n_async,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  o_mem_req_valid,
  output logic                  o_mem_req_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_req_ready,
  input  logic                  i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rsp_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_error,
  output logic                  o_timeout,
  output logic [IDX_WIDTH-1:0]  o_bit_index,
  output logic [DATA_WIDTH-1:0] o_fail_expected,
  output logic [DATA_WIDTH-1:0] o_fail_actual
);

  localparam int                 CNT_W    = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam bit                 TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   pattern;
  logic                    last;
  logic                    load;
  logic                    shift;
  logic                    set_pass;
  logic                    set_error;
  logic                    set_timeout;
  logic                    cnt_clr;
  logic                    cnt_inc;

  mem_test_pattern_walker #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_walker (
    .i_clk         (i_clk),
    .i_rst_n_async (i_rst_n_async),
    .load          (load),
    .mode          (mode_t'(i_mode)),
    .shift         (shift),
    .pattern       (pattern),
    .index         (o_bit_index),
    .last          (last)
  );

  // State register; reset drops the request in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n_async) begin
    if (!i_rst_n_async) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus request outputs and datapath strobes.
  always_comb begin
    state_d         = state_q;
    load            = 1'b0;
    shift           = 1'b0;
    set_pass        = 1'b0;
    set_error       = 1'b0;
    set_timeout     = 1'b0;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_req_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          load    = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_we    = 1'b1;
        if (i_mem_req_ready) begin
          state_d = S_READ_REQ;
        end
      end
      S_READ_REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) begin
          cnt_clr = 1'b1;
          state_d = S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        // A response in the final timeout cycle is still compared.
        if (i_mem_rsp_valid) begin
          if (i_mem_rsp_data == pattern) begin
            state_d = S_NEXT;
          end else begin
            set_error = 1'b1;
            state_d   = S_FAIL;
          end
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          set_timeout = 1'b1;
          state_d     = S_FAIL;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_NEXT: begin
        if (last) begin
          set_pass = 1'b1;
          state_d  = S_DONE;
        end else begin
          shift   = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_FAIL: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read-response wait counter, restarted on every read acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n_async) begin
    if (!i_rst_n_async) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc && TMO_EN) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Test address and result flags; cleared by an accepted start, then held.
  always_ff @(posedge i_clk or negedge i_rst_n_async) begin
    if (!i_rst_n_async) begin
      o_mem_addr      <= '0;
      o_pass          <= 1'b0;
      o_error         <= 1'b0;
      o_timeout       <= 1'b0;
      o_fail_expected <= '0;
      o_fail_actual   <= '0;
    end else if (load) begin
      o_mem_addr      <= i_address;
      o_pass          <= 1'b0;
      o_error         <= 1'b0;
      o_timeout       <= 1'b0;
      o_fail_expected <= '0;
      o_fail_actual   <= '0;
    end else begin
      if (set_pass) begin
        o_pass <= 1'b1;
      end
      if (set_error) begin
        o_error         <= 1'b1;
        o_fail_expected <= pattern;
        o_fail_actual   <= i_mem_rsp_data;
      end
      if (set_timeout) begin
        o_timeout       <= 1'b1;
        o_fail_expected <= pattern;
        o_fail_actual   <= '0;
      end
    end
  end

  assign o_mem_wdata = pattern;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_test_data_bus_walker.sv
// Directed bench for the data-bus walker with a behavioural memory model
// and a write-data scoreboard.
module tb_mem_test_data_bus_walker;
  import mem_test_pkg::*;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int IW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          i_start;
  logic          i_mode;
  logic [AW-1:0] i_address;
  logic          o_mem_req_valid;
  logic          o_mem_req_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_req_ready;
  logic          i_mem_rsp_valid;
  logic [DW-1:0] i_mem_rsp_data;
  logic          o_busy;
  logic          o_done;
  logic          o_pass;
  logic          o_error;
  logic          o_timeout;
  logic [IW-1:0] o_bit_index;
  logic [DW-1:0] o_fail_expected;
  logic [DW-1:0] o_fail_actual;

  mem_test_data_bus_walker #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk           (clk),
    .i_rst_n_async   (rst_n),
    .i_start         (i_start),
    .i_mode          (i_mode),
    .i_address       (i_address),
    .o_mem_req_valid (o_mem_req_valid),
    .o_mem_req_we    (o_mem_req_we),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wdata     (o_mem_wdata),
    .i_mem_req_ready (i_mem_req_ready),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rsp_data  (i_mem_rsp_data),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_pass          (o_pass),
    .o_error         (o_error),
    .o_timeout       (o_timeout),
    .o_bit_index     (o_bit_index),
    .o_fail_expected (o_fail_expected),
    .o_fail_actual   (o_fail_actual)
  );

  // ---------------- scoreboard state ----------------
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  bit            stall_en  = 1'b0;
  bit            no_rsp    = 1'b0;
  logic [DW-1:0] stuck_lo  = '0;
  logic [DW-1:0] mem_data  = '0;
  int            stall_cnt = 0;

  initial begin
    i_mem_req_ready = 1'b1;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data  = '0;
  end

  // Single-location memory: echoes writes, optional stuck-at-0 bits,
  // optional missing responses and random ready stalls after each transfer.
  always @(posedge clk) begin
    automatic int n;
    i_mem_rsp_valid <= 1'b0;
    if (o_mem_req_valid && i_mem_req_ready) begin
      if (o_mem_req_we) begin
        mem_data <= o_mem_wdata;
      end else if (!no_rsp) begin
        i_mem_rsp_valid <= 1'b1;
        i_mem_rsp_data  <= mem_data & ~stuck_lo;
      end
      n = stall_en ? int'($urandom_range(0, 5)) : 0;
      stall_cnt       <= n;
      i_mem_req_ready <= (n == 0);
    end else if (stall_cnt > 0) begin
      stall_cnt       <= stall_cnt - 1;
      i_mem_req_ready <= (stall_cnt == 1);
    end else begin
      i_mem_req_ready <= 1'b1;
    end
  end

  // ---------------- monitor ----------------
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  logic          prev_we;
  logic [DW-1:0] exp_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(o_mem_req_valid), 32'(1));
        check("stall_addr", 32'(o_mem_addr), 32'(prev_addr));
        check("stall_wdata", 32'(o_mem_wdata), 32'(prev_wdata));
        check("stall_we", 32'(o_mem_req_we), 32'(prev_we));
      end
      if (o_mem_req_valid && i_mem_req_ready) begin
        check("req_addr", 32'(o_mem_addr), 32'(exp_addr));
        if (o_mem_req_we) begin
          check("write_expected", 32'(exp_q.size() != 0), 32'(1));
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check("write_data", 32'(o_mem_wdata), 32'(exp_w));
          end
        end
      end
      prev_stall = o_mem_req_valid && !i_mem_req_ready;
      prev_addr  = o_mem_addr;
      prev_wdata = o_mem_wdata;
      prev_we    = o_mem_req_we;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_patterns(input logic mode, input int n);
    logic [DW-1:0] p;
    for (int i = 0; i < n; i++) begin
      p = DW'(1) << i;
      exp_q.push_back(mode ? ~p : p);
    end
  endtask

  // Cycle count includes the start cycle and the o_done cycle.
  task automatic run_test(input logic mode, input logic [AW-1:0] addr, input int n_push,
                          input bit spam, output int cycles);
    exp_addr = addr;
    push_patterns(mode, n_push);
    i_mode    = mode;
    i_address = addr;
    i_start   = 1'b1;
    cycles    = 1;
    @(negedge clk);
    i_start = 1'b0;
    cycles  = 2;
    check("busy_after_start", 32'(o_busy), 32'(1));
    check("pass_cleared", 32'(o_pass), 32'(0));
    check("error_cleared", 32'(o_error), 32'(0));
    check("timeout_cleared", 32'(o_timeout), 32'(0));
    check("fexp_cleared", 32'(o_fail_expected), 32'(0));
    while (!o_done && cycles < 600) begin
      if (spam && $urandom_range(0, 3) == 0) begin
        i_start   = 1'b1;
        i_mode    = ~mode;
        i_address = AW'($urandom_range(0, 16'hFFFF));
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    i_start = 1'b0;
    check("done_seen", 32'(o_done), 32'(1));
  endtask

  task automatic check_after_done();
    @(negedge clk);
    check("done_single_pulse", 32'(o_done), 32'(0));
    check("busy_released", 32'(o_busy), 32'(0));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req_valid"}, 32'(o_mem_req_valid), 32'(0));
    check({pfx, "_req_we"}, 32'(o_mem_req_we), 32'(0));
    check({pfx, "_addr"}, 32'(o_mem_addr), 32'(0));
    check({pfx, "_wdata"}, 32'(o_mem_wdata), 32'(0));
    check({pfx, "_busy"}, 32'(o_busy), 32'(0));
    check({pfx, "_done"}, 32'(o_done), 32'(0));
    check({pfx, "_pass"}, 32'(o_pass), 32'(0));
    check({pfx, "_error"}, 32'(o_error), 32'(0));
    check({pfx, "_timeout"}, 32'(o_timeout), 32'(0));
    check({pfx, "_bit_index"}, 32'(o_bit_index), 32'(0));
    check({pfx, "_fail_expected"}, 32'(o_fail_expected), 32'(0));
    check({pfx, "_fail_actual"}, 32'(o_fail_actual), 32'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  cyc;
    bit  found;
    rst_n     = 1'b0;
    i_start   = 1'b0;
    i_mode    = 1'b0;
    i_address = '0;
    exp_addr  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Walking ones, ideal memory.
    run_test(1'b0, 16'h1234, 8, 1'b0, cyc);
    check("t1_cycles", 32'(cyc), 32'(34));
    check("t1_pass", 32'(o_pass), 32'(1));
    check("t1_error", 32'(o_error), 32'(0));
    check("t1_timeout", 32'(o_timeout), 32'(0));
    check_after_done();

    // Walking zeros, ideal memory.
    run_test(1'b1, 16'hBEEF, 8, 1'b0, cyc);
    check("t2_cycles", 32'(cyc), 32'(34));
    check("t2_pass", 32'(o_pass), 32'(1));
    check("t2_error", 32'(o_error), 32'(0));
    check_after_done();

    // Data bit 3 stuck at 0: abort at the fourth pattern.
    stuck_lo = 8'h08;
    run_test(1'b0, 16'h0042, 4, 1'b0, cyc);
    check("t3_error", 32'(o_error), 32'(1));
    check("t3_pass", 32'(o_pass), 32'(0));
    check("t3_timeout", 32'(o_timeout), 32'(0));
    check("t3_bit_index", 32'(o_bit_index), 32'(3));
    check("t3_fail_expected", 32'(o_fail_expected), 32'(8'h08));
    check("t3_fail_actual", 32'(o_fail_actual), 32'(8'h00));
    check_after_done();
    repeat (5) @(negedge clk);
    stuck_lo = '0;

    // No read responses: time out after 16 wait cycles on bit 0.
    no_rsp = 1'b1;
    run_test(1'b0, 16'h7777, 1, 1'b0, cyc);
    check("t4_cycles", 32'(cyc), 32'(21));
    check("t4_timeout", 32'(o_timeout), 32'(1));
    check("t4_error", 32'(o_error), 32'(0));
    check("t4_pass", 32'(o_pass), 32'(0));
    check("t4_bit_index", 32'(o_bit_index), 32'(0));
    check("t4_fail_expected", 32'(o_fail_expected), 32'(8'h01));
    check("t4_fail_actual", 32'(o_fail_actual), 32'(8'h00));
    check_after_done();
    no_rsp = 1'b0;

    // Random ready stalls and stray starts while busy.
    stall_en = 1'b1;
    run_test(1'b1, AW'($urandom_range(0, 16'hFFFF)), 8, 1'b1, cyc);
    check("t5_pass", 32'(o_pass), 32'(1));
    check("t5_error", 32'(o_error), 32'(0));
    check("t5_timeout", 32'(o_timeout), 32'(0));
    check_after_done();
    stall_en = 1'b0;
    repeat (8) @(negedge clk);

    // Reset while waiting for the bit-4 read response, then a clean rerun.
    exp_addr = 16'h00F0;
    push_patterns(1'b0, 8);
    i_mode    = 1'b0;
    i_address = 16'h00F0;
    i_start   = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (o_bit_index == 3'd4 && o_mem_req_valid && !o_mem_req_we && i_mem_req_ready) begin
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("t6_reached_bit4_read", 32'(found), 32'(1));
    @(negedge clk);
    check("t6_in_read_wait", 32'(dut.state_q), 32'(S_READ_WAIT));
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_test(1'b1, 16'h0A0A, 8, 1'b0, cyc);
    check("t6_cycles", 32'(cyc), 32'(34));
    check("t6_pass", 32'(o_pass), 32'(1));
    check("t6_error", 32'(o_error), 32'(0));
    check("t6_timeout", 32'(o_timeout), 32'(0));
    check("t6_fail_expected", 32'(o_fail_expected), 32'(0));
    check("t6_fail_actual", 32'(o_fail_actual), 32'(0));
    check_after_done();

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
